// File: rtl/video_timing_gen.sv
// Raster timing source: vs/hs/de sync stream plus a co-timed 8-bit YUV
// test-pattern pixel, all outputs registered one cycle after counter state.
module video_timing_gen #(
  parameter int unsigned CNT_V_SIZE = 12,
  parameter int unsigned CNT_H_SIZE = 12,
  parameter int unsigned VSY        = 3,
  parameter int unsigned VBP        = 3,
  parameter int unsigned VAC        = 1080,
  parameter int unsigned VFP        = 3,
  parameter int unsigned HSY        = 1,
  parameter int unsigned HBP        = 3,
  parameter int unsigned HAC        = 1920,
  parameter int unsigned HFP        = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_en,
  input  logic [1:0]            i_pat_sel,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de,
  output logic [CNT_H_SIZE-1:0] o_x,
  output logic [CNT_V_SIZE-1:0] o_y,
  output logic [7:0]            o_y_data,
  output logic [7:0]            o_u_data,
  output logic [7:0]            o_v_data,
  output logic                  o_frame_done
);

  localparam int unsigned H_TOT = HSY + HBP + HAC + HFP;
  localparam int unsigned V_TOT = VSY + VBP + VAC + VFP;
  localparam int unsigned BAR_W = HAC / 8;

  localparam logic [CNT_H_SIZE-1:0] H_LAST    = CNT_H_SIZE'(H_TOT - 1);
  localparam logic [CNT_H_SIZE-1:0] H_SYNC    = CNT_H_SIZE'(HSY);
  localparam logic [CNT_H_SIZE-1:0] H_ACT_BEG = CNT_H_SIZE'(HSY + HBP);
  localparam logic [CNT_H_SIZE-1:0] H_ACT_END = CNT_H_SIZE'(HSY + HBP + HAC - 1);
  localparam logic [CNT_H_SIZE-1:0] BAR_LAST  = CNT_H_SIZE'(BAR_W - 1);
  localparam logic [CNT_V_SIZE-1:0] V_LAST    = CNT_V_SIZE'(V_TOT - 1);
  localparam logic [CNT_V_SIZE-1:0] V_SYNC    = CNT_V_SIZE'(VSY);
  localparam logic [CNT_V_SIZE-1:0] V_ACT_BEG = CNT_V_SIZE'(VSY + VBP);
  localparam logic [CNT_V_SIZE-1:0] V_ACT_END = CNT_V_SIZE'(VSY + VBP + VAC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_e;

  state_e                  state_q, state_d;
  logic [CNT_H_SIZE-1:0]   cnt_h_q, cnt_h_d;
  logic [CNT_V_SIZE-1:0]   cnt_v_q, cnt_v_d;
  logic [CNT_H_SIZE-1:0]   bar_pix_q, bar_pix_d;
  logic [2:0]              bar_idx_q, bar_idx_d;
  logic [1:0]              pat_q;
  logic [7:0]              frame_cnt_q;

  logic                    run_c, h_last_c, v_last_c, frame_end_c;
  logic                    hs_c, vs_c, h_act_c, v_act_c, de_c;
  logic [CNT_H_SIZE-1:0]   x_c;
  logic [CNT_V_SIZE-1:0]   y_c;
  logic [7:0]              pix_y_c, pix_u_c, pix_v_c;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a stopped raster always finishes its frame before idling
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_en) state_d = ST_RUN;
      ST_RUN:  if (!i_en) state_d = ST_STOP;
      ST_STOP: begin
        if (frame_end_c) state_d = ST_IDLE;
        else if (i_en)   state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_c = (state_q != ST_IDLE);
  end

  // Sync/active decode of the current counter state
  always_comb begin
    h_last_c    = (cnt_h_q == H_LAST);
    v_last_c    = (cnt_v_q == V_LAST);
    frame_end_c = run_c && h_last_c && v_last_c;
    hs_c        = run_c && (cnt_h_q < H_SYNC);
    vs_c        = run_c && (cnt_v_q < V_SYNC);
    h_act_c     = (cnt_h_q >= H_ACT_BEG) && (cnt_h_q <= H_ACT_END);
    v_act_c     = (cnt_v_q >= V_ACT_BEG) && (cnt_v_q <= V_ACT_END);
    de_c        = run_c && h_act_c && v_act_c;
    x_c         = cnt_h_q - H_ACT_BEG;
    y_c         = cnt_v_q - V_ACT_BEG;
  end

  // Raster counters and colour-bar position tracker
  always_comb begin
    cnt_h_d   = cnt_h_q;
    cnt_v_d   = cnt_v_q;
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    if (!run_c) begin
      cnt_h_d = '0;
      cnt_v_d = '0;
    end else if (h_last_c) begin
      cnt_h_d = '0;
      cnt_v_d = v_last_c ? '0 : cnt_v_q + CNT_V_SIZE'(1);
    end else begin
      cnt_h_d = cnt_h_q + CNT_H_SIZE'(1);
    end
    if (cnt_h_d == H_ACT_BEG) begin
      bar_pix_d = '0;
      bar_idx_d = '0;
    end else if (h_act_c) begin
      if (bar_pix_q == BAR_LAST) begin
        bar_pix_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + CNT_H_SIZE'(1);
      end
    end
  end

  // Pixel value for the current counter state
  always_comb begin
    pix_y_c = 8'd16;
    pix_u_c = 8'd128;
    pix_v_c = 8'd128;
    if (de_c) begin
      case (pat_q)
        2'd1: begin
          case (bar_idx_q)
            3'd0:    begin pix_y_c = 8'd235; pix_u_c = 8'd128; pix_v_c = 8'd128; end
            3'd1:    begin pix_y_c = 8'd210; pix_u_c = 8'd16;  pix_v_c = 8'd146; end
            3'd2:    begin pix_y_c = 8'd170; pix_u_c = 8'd166; pix_v_c = 8'd16;  end
            3'd3:    begin pix_y_c = 8'd145; pix_u_c = 8'd54;  pix_v_c = 8'd34;  end
            3'd4:    begin pix_y_c = 8'd106; pix_u_c = 8'd202; pix_v_c = 8'd222; end
            3'd5:    begin pix_y_c = 8'd81;  pix_u_c = 8'd90;  pix_v_c = 8'd240; end
            3'd6:    begin pix_y_c = 8'd41;  pix_u_c = 8'd240; pix_v_c = 8'd110; end
            default: begin pix_y_c = 8'd16;  pix_u_c = 8'd128; pix_v_c = 8'd128; end
          endcase
        end
        2'd2:    pix_y_c = x_c[7:0];
        2'd3:    pix_y_c = x_c[7:0] + y_c[7:0] + frame_cnt_q;
        default: pix_y_c = 8'd16;
      endcase
    end
  end

  // Counter, pattern-select and frame-count state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_h_q     <= '0;
      cnt_v_q     <= '0;
      bar_pix_q   <= '0;
      bar_idx_q   <= '0;
      pat_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      cnt_h_q   <= cnt_h_d;
      cnt_v_q   <= cnt_v_d;
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      if (cnt_h_q == '0 && cnt_v_q == '0) pat_q <= i_pat_sel;
      if (frame_end_c) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  // Registered output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_vs         <= 1'b0;
      o_hs         <= 1'b0;
      o_de         <= 1'b0;
      o_x          <= '0;
      o_y          <= '0;
      o_y_data     <= '0;
      o_u_data     <= '0;
      o_v_data     <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_vs         <= vs_c;
      o_hs         <= hs_c;
      o_de         <= de_c;
      o_x          <= de_c ? x_c : '0;
      if (de_c) o_y <= y_c;
      o_y_data     <= pix_y_c;
      o_u_data     <= pix_u_c;
      o_v_data     <= pix_v_c;
      o_frame_done <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small raster (13 x 7 = 91 clocks per frame).
module tb_video_timing_gen;

  localparam int unsigned CH = 12;
  localparam int unsigned CV = 12;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic          en   = 1'b0;
  logic [1:0]    pat  = 2'd0;
  logic          o_vs, o_hs, o_de, o_frame_done;
  logic [CH-1:0] o_x;
  logic [CV-1:0] o_y;
  logic [7:0]    o_y_data, o_u_data, o_v_data;

  always #5 clk = ~clk;

  video_timing_gen #(
    .CNT_V_SIZE(CV), .CNT_H_SIZE(CH),
    .VSY(1), .VBP(1), .VAC(4), .VFP(1),
    .HSY(1), .HBP(2), .HAC(8), .HFP(2)
  ) dut (
    .clk(clk), .rstn(rstn), .i_en(en), .i_pat_sel(pat),
    .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_x(o_x), .o_y(o_y),
    .o_y_data(o_y_data), .o_u_data(o_u_data), .o_v_data(o_v_data),
    .o_frame_done(o_frame_done)
  );

  typedef struct packed {
    logic          vs, hs, de;
    logic [CH-1:0] x;
    logic [CV-1:0] y;
    logic [7:0]    yd, ud, vd;
    logic          fd;
  } out_t;

  typedef struct {
    bit       en;
    bit [1:0] pat;
    int       ncyc;
    bit       rst_before;
    int       e_de, e_hs, e_vs, e_fd, e_first, e_last;
  } seg_t;

  out_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state: 0 idle, 1 run, 2 stop; position within the 91-clock frame
  int       m_state, m_pos, m_y, m_fc;
  logic [1:0] m_pat;
  logic [7:0] bar_y [8] = '{8'd235, 8'd210, 8'd170, 8'd145, 8'd106, 8'd81, 8'd41, 8'd16};
  logic [7:0] bar_u [8] = '{8'd128, 8'd16, 8'd166, 8'd54, 8'd202, 8'd90, 8'd240, 8'd128};
  logic [7:0] bar_v [8] = '{8'd128, 8'd146, 8'd16, 8'd34, 8'd222, 8'd240, 8'd110, 8'd128};

  int s_de, s_hs, s_vs, s_fd, s_first, s_last;

  function automatic out_t dut_out();
    out_t o;
    o.vs = o_vs; o.hs = o_hs; o.de = o_de; o.x = o_x; o.y = o_y;
    o.yd = o_y_data; o.ud = o_u_data; o.vd = o_v_data; o.fd = o_frame_done;
    return o;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_y = 0; m_fc = 0; m_pat = 2'd0;
  endtask

  task automatic model_step(input logic e, input logic [1:0] p, output out_t ex);
    int col, line, xx;
    ex = '0;
    ex.yd = 8'd16; ex.ud = 8'd128; ex.vd = 8'd128;
    if (m_state != 0) begin
      if (m_pos == 0) m_pat = p;
      col  = m_pos % 13;
      line = m_pos / 13;
      ex.hs = (col == 0);
      ex.vs = (line == 0);
      ex.de = (col >= 3) && (col <= 10) && (line >= 2) && (line <= 5);
      if (ex.de) begin
        xx   = col - 3;
        m_y  = line - 2;
        ex.x = CH'(xx);
        case (m_pat)
          2'd1: begin ex.yd = bar_y[xx]; ex.ud = bar_u[xx]; ex.vd = bar_v[xx]; end
          2'd2: ex.yd = 8'(xx);
          2'd3: ex.yd = 8'(xx + m_y + m_fc);
          default: ;
        endcase
      end
      ex.fd = (m_pos == 90);
    end
    ex.y = CV'(m_y);
    case (m_state)
      0: if (e) m_state = 1;
      1: begin
        if (m_pos == 90) begin m_pos = 0; m_fc = m_fc + 1; end
        else m_pos = m_pos + 1;
        if (!e) m_state = 2;
      end
      default: begin
        if (m_pos == 90) begin m_pos = 0; m_fc = m_fc + 1; m_state = 0; end
        else begin m_pos = m_pos + 1; if (e) m_state = 1; end
      end
    endcase
  endtask

  // one clock: push the model prediction, then pop and compare after the edge
  task automatic cycle();
    out_t ex, got;
    if (!rstn) begin model_reset(); ex = '0; end
    else model_step(en, pat, ex);
    exp_q.push_back(ex);
    @(posedge clk); #1;
    got = dut_out();
    ex  = exp_q.pop_front();
    n_vec++;
    if (got !== ex) begin
      n_err++;
      $display("FAIL sb t=%0t got=%h exp=%h", $time, got, ex);
    end
    s_de += int'(got.de); s_hs += int'(got.hs); s_vs += int'(got.vs); s_fd += int'(got.fd);
    if (got.de) begin
      if (s_first < 0) s_first = int'(got.yd);
      s_last = int'(got.yd);
    end
  endtask

  task automatic check_int(input string name, input int idx, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s seg=%0d got=%0d exp=%0d", name, idx, got, exp);
    end
  endtask

  seg_t segs[14];

  initial begin
    segs[0]  = '{1'b1, 2'd0, 92, 1'b1, 32, 7, 13, 1, 16, 16};
    segs[1]  = '{1'b1, 2'd1, 91, 1'b0, 32, 7, 13, 1, 235, 16};
    segs[2]  = '{1'b1, 2'd0, 40, 1'b0, 8, 4, 13, 0, 16, 16};
    segs[3]  = '{1'b1, 2'd2, 51, 1'b0, 24, 3, 0, 1, 16, 16};
    segs[4]  = '{1'b1, 2'd2, 91, 1'b0, 32, 7, 13, 1, 0, 7};
    segs[5]  = '{1'b1, 2'd2, 30, 1'b0, 1, 3, 13, 0, 0, 0};
    segs[6]  = '{1'b1, 2'd3, 92, 1'b1, 32, 7, 13, 1, 0, 10};
    segs[7]  = '{1'b1, 2'd3, 91, 1'b0, 32, 7, 13, 1, 1, 11};
    segs[8]  = '{1'b1, 2'd3, 91, 1'b0, 32, 7, 13, 1, 2, 12};
    segs[9]  = '{1'b1, 2'd3, 26, 1'b0, 0, 2, 13, 0, -1, -1};
    segs[10] = '{1'b0, 2'd3, 65, 1'b0, 32, 5, 0, 1, 3, 13};
    segs[11] = '{1'b0, 2'd3, 30, 1'b0, 0, 0, 0, 0, -1, -1};
    segs[12] = '{1'b1, 2'd0, 2, 1'b0, 0, 1, 1, 0, -1, -1};
    segs[13] = '{1'b1, 2'd0, 90, 1'b0, 32, 6, 12, 1, 16, 16};

    model_reset();
    #2;
    for (int i = 0; i < 14; i++) begin
      if (segs[i].rst_before) begin
        rstn = 1'b0;
        #1;
        n_vec++;
        if (dut_out() !== out_t'('0)) begin
          n_err++;
          $display("FAIL async_rst seg=%0d got=%h exp=0", i, dut_out());
        end
        cycle();
        cycle();
        rstn = 1'b1;
      end
      en  = segs[i].en;
      pat = segs[i].pat;
      s_de = 0; s_hs = 0; s_vs = 0; s_fd = 0; s_first = -1; s_last = -1;
      for (int c = 0; c < segs[i].ncyc; c++) cycle();
      check_int("de_count", i, s_de, segs[i].e_de);
      check_int("hs_count", i, s_hs, segs[i].e_hs);
      check_int("vs_count", i, s_vs, segs[i].e_vs);
      check_int("frame_done_count", i, s_fd, segs[i].e_fd);
      if (segs[i].e_first >= 0) begin
        check_int("first_pixel_y", i, s_first, segs[i].e_first);
        check_int("last_pixel_y", i, s_last, segs[i].e_last);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster source for the image-filter pipeline: generates the vs/hs/de sync stream that the filter front end consumes, plus a co-timed 8-bit YUV test-pattern pixel per cycle.
- Sits upstream of the filter FSM and line memories, and is used as the frame source in block-level and top-level benches.
- Sync polarity, porch layout and defaults match the filter's timing constants.

Parameters:
CNT_V_SIZE, 12, vertical counter width
CNT_H_SIZE, 12, horizontal counter width
VSY, 3, vsync width in lines
VBP, 3, vertical back porch in lines
VAC, 1080, active lines
VFP, 3, vertical front porch in lines
HSY, 1, hsync width in clocks
HBP, 3, horizontal back porch in clocks
HAC, 1920, active pixels per line; must be a multiple of 8
HFP, 3, horizontal front porch in clocks

Ports:
clk  in  1  pixel clock
rstn  in  1  asynchronous active-low reset
i_en  in  1  run request; level-sensitive
i_pat_sel  in  2  pattern: 0 black, 1 colour bars, 2 ramp, 3 moving ramp
o_vs  out  1  vertical sync, active high
o_hs  out  1  horizontal sync, active high
o_de  out  1  active-pixel valid
o_x  out  CNT_H_SIZE  active pixel column, 0..HAC-1; 0 when o_de=0
o_y  out  CNT_V_SIZE  active line index, 0..VAC-1; holds last value outside active lines
o_y_data  out  8  luma
o_u_data  out  8  Cb
o_v_data  out  8  Cr
o_frame_done  out  1  one-cycle pulse on the last clock of each frame

Behaviour:
- Clock domain and reset: one clock, clk. Asynchronous active-low reset, rstn. All outputs are registered. On reset every output is 0, counters are 0 and the FSM is in ST_IDLE.
- Totals: H_TOT = HSY+HBP+HAC+HFP; V_TOT = VSY+VBP+VAC+VFP.
- Internal counters:
  - r_cnt_h runs 0..H_TOT-1 and wraps.
  - r_cnt_v increments when r_cnt_h wraps, runs 0..V_TOT-1 and wraps.
  - Both counters are held at 0 in ST_IDLE.
- FSM states: ST_IDLE, ST_RUN, ST_STOP.
  - ST_IDLE -> ST_RUN when i_en=1; counting starts the next cycle at (h=0, v=0).
  - ST_RUN -> ST_STOP when i_en=0.
  - ST_STOP -> ST_RUN when i_en=1 again before frame end; the frame is never aborted.
  - ST_STOP -> ST_IDLE at frame end (h=H_TOT-1, v=V_TOT-1).
  - ST_RUN at frame end with i_en=1 continues seamlessly to the next frame.
- Sync decode from counters (c = r_cnt_h, r = r_cnt_v), registered so all outputs are aligned one cycle after the counter state:
  - hs = (c < HSY), on every line, including vertical blanking.
  - vs = (r < VSY), held for whole lines.
  - de = (c in [HSY+HBP, HSY+HBP+HAC-1]) and (r in [VSY+VBP, VSY+VBP+VAC-1]).
  - x = c-(HSY+HBP); y = r-(VSY+VBP).
  - In ST_IDLE: vs=hs=de=0.
- Pattern select: i_pat_sel is sampled only at frame start (counter state h=0, v=0). Mid-frame changes are ignored.
- Pattern 0 (black): Y=16, U=128, V=128.
- Pattern 1 (colour bars): 8 bars, each HAC/8 pixels wide. The bar index comes from a bar-width counter, not a divider. Values per bar, 0..7:
  - Y = 235,210,170,145,106,81,41,16
  - U = 128,16,166,54,202,90,240,128
  - V = 128,146,16,34,222,240,110,128
- Pattern 2 (ramp): Y = x[7:0], U=V=128.
- Pattern 3 (moving ramp): Y = (x+y+frame_cnt)[7:0], U=V=128. frame_cnt is 8 bits, increments at each frame end and wraps 255->0.
- Outside de: Y=16, U=V=128 for all patterns.
- o_frame_done: a 1-cycle pulse in the same output cycle as the last pixel clock of the frame (h=H_TOT-1, v=V_TOT-1). It fires also in ST_STOP.
- Reset mid-frame: all outputs are forced to 0 immediately; operation restarts from ST_IDLE.
- Width rule: counters use CNT_*_SIZE bits; H_TOT and V_TOT must fit in them. The pattern sum is truncated modulo 256.

Test Plan:
- Small timing (HSY=1, HBP=2, HAC=8, HFP=2, VSY=1, VBP=1, VAC=4, VFP=1), i_en=1 from reset:
  - hs is high 1 of every 13 clocks.
  - vs is high for the first 13 clocks of each 91-clock frame.
  - 32 de cycles per frame; x steps 0..7 and y steps 0..3.
  - o_frame_done pulses every 91 clocks.
- Pattern 1, HAC=8: the active line outputs Y = 235,210,170,145,106,81,41,16 and U = 128,16,166,54,202,90,240,128, one value per pixel.
- Deassert i_en mid-frame (at v=2):
  - The frame completes with 32 de cycles, then o_frame_done.
  - Afterwards vs, hs and de stay 0 and no further frame_done occurs.
  - Re-asserting i_en restarts with hs at the next clock +1.
- Change i_pat_sel from 0 to 2 mid-frame: the current frame stays Y=16. The next frame's first de pixel has Y=0, and the last pixel of the line has Y=7.
- Pattern 3 over 3 frames: the first pixel (x=0, y=0) has Y = 0, 1, 2 respectively.
- Assert rstn low during an active pixel: all outputs are 0 asynchronously. After release with i_en=1, counting restarts from (0,0) and the first frame is complete.
